fractal_sync_rf_arbiter: RTL and testbench

FRACTAL_SYNC_RF_ARBITER -- requirements
Module: fractal_sync_rf_arbiter

---
 rtl/fractal_sync_rf_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_fractal_sync_rf_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_sync_rf_arbiter.sv
// Round-robin arbiter that shares N_PORTS remote register-file ports among
// N_REQ fractal-sync requesters, each running an IDLE/PEND/RSP handshake FSM.

module fractal_sync_rf_lane #(
  parameter int LEVEL_WIDTH = 1,
  parameter int ID_WIDTH    = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  input  logic [LEVEL_WIDTH-1:0] req_level_i,
  input  logic [ID_WIDTH-1:0]    req_id_i,
  input  logic                   req_check_i,
  output logic                   req_ready_o,
  output logic                   pend_o,
  output logic [LEVEL_WIDTH-1:0] lat_level_o,
  output logic [ID_WIDTH-1:0]    lat_id_o,
  output logic                   lat_check_o,
  input  logic                   gnt_i,
  input  logic [3:0]             res_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [3:0]             rsp_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, RSP = 2'd2} state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = PEND;
      PEND:    if (gnt_i)       state_d = RSP;
      RSP:     if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request payload is captured on acceptance; results only at the grant cycle,
  // so rsp_o stays frozen through RSP back-pressure and the following IDLE/PEND.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lat_level_o <= '0;
      lat_id_o    <= '0;
      lat_check_o <= 1'b0;
      rsp_o       <= '0;
    end else begin
      if (state_q == IDLE && req_valid_i) begin
        lat_level_o <= req_level_i;
        lat_id_o    <= req_id_i;
        lat_check_o <= req_check_i;
      end
      if (state_q == PEND && gnt_i) rsp_o <= res_i;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign pend_o      = (state_q == PEND);
  assign rsp_valid_o = (state_q == RSP);

endmodule

module fractal_sync_rf_arbiter #(
  parameter int N_REQ       = 4,
  parameter int N_PORTS     = 2,
  parameter int LEVEL_WIDTH = 1,
  parameter int ID_WIDTH    = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [N_REQ-1:0]                    req_valid_i,
  output logic [N_REQ-1:0]                    req_ready_o,
  input  logic [N_REQ-1:0][LEVEL_WIDTH-1:0]   req_level_i,
  input  logic [N_REQ-1:0][ID_WIDTH-1:0]      req_id_i,
  input  logic [N_REQ-1:0]                    req_check_i,
  output logic [N_REQ-1:0]                    rsp_valid_o,
  input  logic [N_REQ-1:0]                    rsp_ready_i,
  output logic [N_REQ-1:0]                    rsp_present_o,
  output logic [N_REQ-1:0]                    rsp_sig_err_o,
  output logic [N_REQ-1:0]                    rsp_bypass_o,
  output logic [N_REQ-1:0]                    rsp_ignore_o,
  output logic [N_PORTS-1:0][LEVEL_WIDTH-1:0] rf_level_o,
  output logic [N_PORTS-1:0][ID_WIDTH-1:0]    rf_id_o,
  output logic [N_PORTS-1:0]                  rf_check_o,
  input  logic [N_PORTS-1:0]                  rf_present_i,
  input  logic [N_PORTS-1:0]                  rf_sig_err_i,
  input  logic [N_PORTS-1:0]                  rf_bypass_i,
  input  logic [N_PORTS-1:0]                  rf_ignore_i,
  output logic                                busy_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0]                  rr_q, rr_d;
  logic [N_REQ-1:0]                  pend, gnt;
  logic [N_REQ-1:0][LEVEL_WIDTH-1:0] lat_level;
  logic [N_REQ-1:0][ID_WIDTH-1:0]    lat_id;
  logic [N_REQ-1:0]                  lat_check;
  logic [N_REQ-1:0][3:0]             res, rsp;
  int                                pos  [N_REQ];
  int                                rank [N_REQ];
  int                                last_pos;

  // A requester's rank is the number of pending requesters ahead of it in
  // scan order from rr_q; the first N_PORTS ranks map straight onto ports.
  always_comb begin
    gnt        = '0;
    rr_d       = rr_q;
    last_pos   = -1;
    res        = '0;
    rf_level_o = '0;
    rf_id_o    = '0;
    rf_check_o = '0;
    for (int r = 0; r < N_REQ; r++) pos[r] = (r + N_REQ - int'(rr_q)) % N_REQ;
    for (int r = 0; r < N_REQ; r++) begin
      rank[r] = 0;
      for (int s = 0; s < N_REQ; s++)
        if (pend[s] && pos[s] < pos[r]) rank[r] = rank[r] + 1;
    end
    for (int r = 0; r < N_REQ; r++) begin
      if (pend[r] && rank[r] < N_PORTS) begin
        gnt[r] = 1'b1;
        if (pos[r] > last_pos) begin
          last_pos = pos[r];
          rr_d     = IDX_W'((r + 1) % N_REQ);
        end
      end
    end
    for (int p = 0; p < N_PORTS; p++) begin
      for (int r = 0; r < N_REQ; r++) begin
        if (gnt[r] && rank[r] == p) begin
          rf_level_o[p] = lat_level[r];
          rf_id_o[p]    = lat_id[r];
          rf_check_o[p] = lat_check[r] & ~rst_i;
          res[r]        = {rf_present_i[p], rf_sig_err_i[p], rf_bypass_i[p], rf_ignore_i[p]};
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rr_q <= '0;
    else       rr_q <= rr_d;
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    fractal_sync_rf_lane #(
      .LEVEL_WIDTH (LEVEL_WIDTH),
      .ID_WIDTH    (ID_WIDTH)
    ) u_lane (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i[g]),
      .req_level_i (req_level_i[g]),
      .req_id_i    (req_id_i[g]),
      .req_check_i (req_check_i[g]),
      .req_ready_o (req_ready_o[g]),
      .pend_o      (pend[g]),
      .lat_level_o (lat_level[g]),
      .lat_id_o    (lat_id[g]),
      .lat_check_o (lat_check[g]),
      .gnt_i       (gnt[g]),
      .res_i       (res[g]),
      .rsp_valid_o (rsp_valid_o[g]),
      .rsp_ready_i (rsp_ready_i[g]),
      .rsp_o       (rsp[g])
    );
    assign rsp_present_o[g] = rsp[g][3];
    assign rsp_sig_err_o[g] = rsp[g][2];
    assign rsp_bypass_o[g]  = rsp[g][1];
    assign rsp_ignore_o[g]  = rsp[g][0];
  end

  assign busy_o = ~(&req_ready_o);

endmodule

// File: tb/tb_fractal_sync_rf_arbiter.sv
// Randomized scoreboard bench for fractal_sync_rf_arbiter: a request-level model
// predicts port drive, handshake flags and responses; a monitor checks them.

module tb_fractal_sync_rf_arbiter;

  localparam int N   = 4;
  localparam int P   = 2;
  localparam int LW  = 1;
  localparam int IW  = 1;
  localparam int LVW = N * LW;
  localparam int IDW = N * IW;
  localparam int T   = 700;

  logic                  clk, rst;
  logic [N-1:0]          req_valid_i, req_ready_o, req_check_i;
  logic [N-1:0][LW-1:0]  req_level_i;
  logic [N-1:0][IW-1:0]  req_id_i;
  logic [N-1:0]          rsp_valid_o, rsp_ready_i;
  logic [N-1:0]          rsp_present_o, rsp_sig_err_o, rsp_bypass_o, rsp_ignore_o;
  logic [P-1:0][LW-1:0]  rf_level_o;
  logic [P-1:0][IW-1:0]  rf_id_o;
  logic [P-1:0]          rf_check_o;
  logic [P-1:0]          rf_present_i, rf_sig_err_i, rf_bypass_i, rf_ignore_i;
  logic                  busy_o;

  fractal_sync_rf_arbiter #(.N_REQ(N), .N_PORTS(P), .LEVEL_WIDTH(LW), .ID_WIDTH(IW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_level_i(req_level_i), .req_id_i(req_id_i), .req_check_i(req_check_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_present_o(rsp_present_o), .rsp_sig_err_o(rsp_sig_err_o),
    .rsp_bypass_o(rsp_bypass_o), .rsp_ignore_o(rsp_ignore_o),
    .rf_level_o(rf_level_o), .rf_id_o(rf_id_o), .rf_check_o(rf_check_o),
    .rf_present_i(rf_present_i), .rf_sig_err_i(rf_sig_err_i),
    .rf_bypass_i(rf_bypass_i), .rf_ignore_i(rf_ignore_i),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [P-1:0][LW-1:0] lvl;
    logic [P-1:0][IW-1:0] id;
    logic [P-1:0]         chk;
    logic [N-1:0]         rdy;
    logic [N-1:0]         vld;
    logic                 busy;
    logic [N-1:0][3:0]    rsp;
  } cyc_t;

  cyc_t       cyc_q [$];
  logic [3:0] rsp_q [N][$];

  int n_checks = 0;
  int n_fail   = 0;
  int fair_cnt [N];
  bit fair_on  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expected cycle view per cycle, plus response scoreboard on handshakes.
  int pw [N];
  always @(negedge clk) begin : mon
    cyc_t              e;
    logic [N-1:0][3:0] got;
    for (int r = 0; r < N; r++)
      got[r] = {rsp_present_o[r], rsp_sig_err_o[r], rsp_bypass_o[r], rsp_ignore_o[r]};
    if (cyc_q.size() != 0) begin
      e = cyc_q.pop_front();
      chk("rf_level",  32'(rf_level_o),  32'(e.lvl));
      chk("rf_id",     32'(rf_id_o),     32'(e.id));
      chk("rf_check",  32'(rf_check_o),  32'(e.chk));
      chk("req_ready", 32'(req_ready_o), 32'(e.rdy));
      chk("rsp_valid", 32'(rsp_valid_o), 32'(e.vld));
      chk("busy",      32'(busy_o),      32'(e.busy));
      chk("rsp_payload_hold", 32'(got),  32'(e.rsp));
    end
    for (int r = 0; r < N; r++) begin
      if (rsp_valid_o[r] === 1'b1 && rsp_ready_i[r] && !rst) begin
        if (fair_on) fair_cnt[r]++;
        if (rsp_q[r].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: requester %0d got response %0h with none outstanding", r, got[r]);
        end else begin
          chk("rsp_handshake", 32'(got[r]), 32'(rsp_q[r].pop_front()));
        end
      end
      if (!rst && req_ready_o[r] === 1'b0 && rsp_valid_o[r] === 1'b0) begin
        pw[r]++;
      end else begin
        if (pw[r] != 0) chk("pend_wait_le_2", 32'(pw[r] <= 2), 32'd1);
        pw[r] = 0;
      end
    end
  end

  // Model state: 0 = idle, 1 = waiting for a port, 2 = holding a response.
  int               st [N];
  int               nst [N];
  logic [LW-1:0]    m_lvl [N];
  logic [IW-1:0]    m_id  [N];
  logic             m_chk [N];
  logic [3:0]       m_rsp [N];
  int               rr, rr_nx, g;
  int               gp [P];
  logic [3:0]       pres [P];
  bit               prst;
  logic [N-1:0]     pval, prdy, pchk;
  logic [N-1:0][LW-1:0] plvl;
  logic [N-1:0][IW-1:0] pid;
  cyc_t             e;
  int               mn, mx;

  initial begin
    rst = 1'b1;
    req_valid_i = '0; req_level_i = '0; req_id_i = '0; req_check_i = '0;
    rsp_ready_i = '0;
    rf_present_i = '0; rf_sig_err_i = '0; rf_bypass_i = '0; rf_ignore_i = '0;
    prst = 1'b1; rr = 0; rr_nx = 0;
    pval = '0; prdy = '0; plvl = '0; pid = '0; pchk = '0;
    for (int p = 0; p < P; p++) begin gp[p] = -1; pres[p] = '0; end
    for (int r = 0; r < N; r++) begin
      st[r] = 0; m_lvl[r] = '0; m_id[r] = '0; m_chk[r] = 1'b0; m_rsp[r] = '0;
      fair_cnt[r] = 0; pw[r] = 0;
    end

    for (int t = 0; t < T; t++) begin
      @(posedge clk);
      #1;
      // Retire the effects of the previous cycle.
      if (prst) begin
        rr = 0;
        for (int r = 0; r < N; r++) begin
          st[r] = 0; m_rsp[r] = '0; rsp_q[r].delete();
        end
      end else begin
        for (int r = 0; r < N; r++) begin
          nst[r] = st[r];
          if (st[r] == 0 && pval[r]) begin
            nst[r] = 1; m_lvl[r] = plvl[r]; m_id[r] = pid[r]; m_chk[r] = pchk[r];
          end
          if (st[r] == 2 && prdy[r]) nst[r] = 0;
        end
        for (int p = 0; p < P; p++) begin
          if (gp[p] >= 0) begin
            nst[gp[p]]   = 2;
            m_rsp[gp[p]] = pres[p];
            rsp_q[gp[p]].push_back(pres[p]);
          end
        end
        for (int r = 0; r < N; r++) st[r] = nst[r];
        rr = rr_nx;
      end

      // Stimulus for this cycle.
      rst          = (t < 2) || (t == 150) || (t >= 201 && $urandom_range(0, 49) == 0);
      req_level_i  = LVW'($urandom);
      req_id_i     = IDW'($urandom);
      req_check_i  = N'($urandom);
      rf_present_i = P'($urandom);
      rf_sig_err_i = P'($urandom);
      rf_bypass_i  = P'($urandom);
      rf_ignore_i  = P'($urandom);
      if (t == 2) begin
        req_valid_i = 4'b0001; req_level_i[0] = 1'b1; req_id_i[0] = 1'b1; req_check_i[0] = 1'b1;
        rsp_ready_i = '1;
      end else if (t < 100) begin
        req_valid_i = N'($urandom);
        for (int r = 0; r < N; r++) rsp_ready_i[r] = ($urandom_range(0, 9) < 7);
      end else if (t < 150) begin
        req_valid_i = '1;
        rsp_ready_i = (t <= 130) ? 4'b1101 : 4'b1111;
      end else if (t <= 200) begin
        req_valid_i = '1;
        rsp_ready_i = '1;
      end else begin
        req_valid_i = N'($urandom);
        for (int r = 0; r < N; r++) rsp_ready_i[r] = ($urandom_range(0, 9) < 6);
      end
      fair_on = (t >= 152 && t <= 191);

      // Grants: scan from the round-robin pointer, first P waiting requesters win.
      g = 0;
      rr_nx = rr;
      for (int p = 0; p < P; p++) gp[p] = -1;
      for (int k = 0; k < N; k++) begin
        int r;
        r = (rr + k) % N;
        if (st[r] == 1 && g < P) begin
          gp[g] = r; g++; rr_nx = (r + 1) % N;
        end
      end

      e = '0;
      for (int p = 0; p < P; p++) begin
        if (gp[p] >= 0) begin
          e.lvl[p] = m_lvl[gp[p]];
          e.id[p]  = m_id[gp[p]];
          e.chk[p] = m_chk[gp[p]] & ~rst;
          pres[p]  = {rf_present_i[p], rf_sig_err_i[p], rf_bypass_i[p], rf_ignore_i[p]};
        end
      end
      for (int r = 0; r < N; r++) begin
        e.rdy[r] = (st[r] == 0);
        e.vld[r] = (st[r] == 2);
        e.rsp[r] = m_rsp[r];
        if (st[r] != 0) e.busy = 1'b1;
      end
      if (t > 0) cyc_q.push_back(e);

      prst = rst; pval = req_valid_i; prdy = rsp_ready_i;
      plvl = req_level_i; pid = req_id_i; pchk = req_check_i;

      if (t == 195) begin
        mn = fair_cnt[0]; mx = fair_cnt[0];
        for (int r = 1; r < N; r++) begin
          if (fair_cnt[r] < mn) mn = fair_cnt[r];
          if (fair_cnt[r] > mx) mx = fair_cnt[r];
        end
        chk("fairness_spread_le_1", 32'(mx - mn <= 1), 32'd1);
        chk("fairness_nonzero", 32'(mn > 0), 32'd1);
      end
    end

    @(negedge clk);
    #1;
    chk("expect_queue_drained", 32'(cyc_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
